// File: rtl/mem_stage_if.sv
// Byte-wide data-RAM bus between mem_stage (master) and the data RAM (slave).
// One byte per req/ack transaction; ram_din is valid while ram_ack is high.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              ram_en;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              ram_ack;

  modport master (output ram_en, ram_wr, ram_addr, ram_dout, input ram_din, ram_ack);
  modport slave  (input ram_en, ram_wr, ram_addr, ram_dout, output ram_din, ram_ack);
endinterface

// File: rtl/mem_stage.sv
// RISC-V MEM stage: byte-serial loads/stores over a req/ack RAM bus, stalling meanwhile.
// Optional macro MEM_STAGE_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_stage #(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_waddr,
  input  logic [31:0] mem_wdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stall_mem,
  output logic        misalign_err,
  mem_stage_if.master ram
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  state_t            state, state_nx;
  logic [1:0]        idx, last;
  logic [2:0]        op_rd;
  logic              op_ld, wreg_q, tmo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q, acc;
  logic [4:0]        wd_q;
  logic [TW-1:0]     tcnt;

  logic       is_ld, is_st, is_mem, misal, tmo_hit;
  logic [1:0] len_m1;
  logic [31:0] ld_val;

  // Decode: a valid read kind wins over any store kind
  always_comb begin
    is_ld  = (mem_read != 3'd0) && (mem_read < 3'd6);
    is_st  = !is_ld && (mem_write != 2'd0);
    is_mem = is_ld || is_st;
    len_m1 = 2'd0;
    if (is_ld) begin
      case (mem_read)
        3'd2, 3'd5: len_m1 = 2'd1;
        3'd3:       len_m1 = 2'd3;
        default:    len_m1 = 2'd0;
      endcase
    end else begin
      case (mem_write)
        2'd2:    len_m1 = 2'd1;
        2'd3:    len_m1 = 2'd3;
        default: len_m1 = 2'd0;
      endcase
    end
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    misal = is_mem && (((len_m1 == 2'd1) && mem_waddr[0]) ||
                       ((len_m1 == 2'd3) && (mem_waddr[1:0] != 2'd0)));
`else
    misal = 1'b0;
`endif
  end

  assign tmo_hit = (ACK_TIMEOUT > 0) && (32'(tcnt) == 32'(ACK_TIMEOUT - 1));

  always_comb begin
    case (op_rd)
      3'd1:    ld_val = {{24{acc[7]}}, acc[7:0]};
      3'd4:    ld_val = {24'd0, acc[7:0]};
      3'd2:    ld_val = {{16{acc[15]}}, acc[15:0]};
      3'd5:    ld_val = {16'd0, acc[15:0]};
      default: ld_val = acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    stall_mem    = 1'b0;
    misalign_err = 1'b0;
    wb_wd        = mem_wd;
    wb_wreg      = 1'b0;
    wb_wdata     = mem_wdata;
    ram.ram_en   = 1'b0;
    case (state)
      IDLE: begin
        if (!is_mem) begin
          wb_wreg = mem_wreg;
        end else if (misal) begin
          misalign_err = 1'b1;
          wb_wdata     = mem_waddr;
        end else begin
          stall_mem = 1'b1;
          state_nx  = REQ;
        end
      end
      REQ: begin
        ram.ram_en = 1'b1;
        stall_mem  = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        ram.ram_en = 1'b1;
        stall_mem  = 1'b1;
        if (ram.ram_ack) state_nx = (idx == last) ? FIN : REQ;
        else if (tmo_hit) state_nx = FIN;
      end
      FIN: begin
        wb_wd    = wd_q;
        wb_wreg  = wreg_q && !tmo_q;
        wb_wdata = op_ld ? ld_val : data_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Outputs are forced quiet while reset is held, including the passthrough path
    if (rst) begin
      stall_mem    = 1'b0;
      misalign_err = 1'b0;
      wb_wd        = 5'd0;
      wb_wreg      = 1'b0;
      wb_wdata     = 32'd0;
    end
  end

  assign ram.ram_wr   = ram.ram_en && !op_ld;
  assign ram.ram_addr = ram.ram_en ? addr_q + {{(ADDR_W-2){1'b0}}, idx} : '0;
  assign ram.ram_dout = ram.ram_en ? data_q[8*idx +: 8] : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0; last <= '0; op_rd <= '0; op_ld <= 1'b0; wreg_q <= 1'b0;
      tmo_q <= 1'b0; addr_q <= '0; data_q <= '0; acc <= '0; wd_q <= '0; tcnt <= '0;
    end else begin
      case (state)
        IDLE: if (is_mem && !misal) begin
          idx    <= '0;
          last   <= len_m1;
          op_rd  <= is_ld ? mem_read : 3'd0;
          op_ld  <= is_ld;
          addr_q <= mem_waddr[ADDR_W-1:0];
          data_q <= mem_wdata;
          wd_q   <= mem_wd;
          wreg_q <= mem_wreg;
          acc    <= '0;
          tmo_q  <= 1'b0;
        end
        REQ: tcnt <= '0;
        WAIT: begin
          if (ram.ram_ack) begin
            if (op_ld) acc[8*idx +: 8] <= ram.ram_din;
            if (idx != last) idx <= idx + 2'd1;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tmo_hit) tmo_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table plus reset-mid-access and slow-ack sequences.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_waddr, mem_wdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg, stall_mem, misalign_err;
  logic [31:0] wb_wdata;

  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_W(32)) ram ();

  mem_stage #(.ADDR_W(32), .ACK_TIMEOUT(0)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_wd(mem_wd),
    .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wb_wd(wb_wd),
    .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .stall_mem(stall_mem),
    .misalign_err(misalign_err), .ram(ram)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // RAM responder: ack after ack_dly cycles of en, logs each completed byte
  typedef struct { logic [31:0] a; logic wr; logic [7:0] d; } txn_t;
  txn_t        log_q[$];
  logic [7:0]  mem [256];
  int          ack_dly = 1;
  int          cnt = 0;
  int          instab = 0;
  int          misal_seen = 0;
  logic [31:0] req_a;
  logic        req_wr;
  logic [7:0]  req_d;

  always @(negedge clk) begin
    if (rst) begin
      ram.ram_ack <= 1'b0;
      cnt         <= 0;
    end else if (ram.ram_ack) begin
      ram.ram_ack <= 1'b0;
      cnt         <= ram.ram_en ? 1 : 0;
      if (ram.ram_en) begin
        req_a <= ram.ram_addr; req_wr <= ram.ram_wr; req_d <= ram.ram_dout;
      end
    end else if (ram.ram_en) begin
      if (cnt == 0) begin
        req_a <= ram.ram_addr; req_wr <= ram.ram_wr; req_d <= ram.ram_dout;
      end else if (ram.ram_addr !== req_a || ram.ram_wr !== req_wr || ram.ram_dout !== req_d) begin
        instab <= instab + 1;
      end
      cnt <= cnt + 1;
      if (cnt + 1 == ack_dly + 1) begin
        ram.ram_ack <= 1'b1;
        ram.ram_din <= mem[ram.ram_addr[7:0]];
        log_q.push_back('{a: ram.ram_addr, wr: ram.ram_wr, d: ram.ram_dout});
      end
    end
    if (misalign_err) misal_seen <= misal_seen + 1;
  end

  typedef struct {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  wd;
    logic        wreg;
    int          exp_stall;   // 0 = non-memory passthrough
    logic [31:0] exp_data;
    logic        exp_wreg;
  } vec_t;
  vec_t vq[$];

  task automatic bubble();
    mem_read = 3'd0; mem_write = 2'd0; mem_wd = 5'd0; mem_wreg = 1'b0;
    mem_waddr = 32'd0; mem_wdata = 32'd0;
  endtask

  task automatic run_op(input vec_t v, input int i);
    int  stalls, bad_wreg, n, nb;
    bit  fin, ld;
    @(negedge clk);
    log_q.delete();
    mem_read = v.rd; mem_write = v.wr; mem_waddr = v.a; mem_wdata = v.d;
    mem_wd = v.wd; mem_wreg = v.wreg;
    #1;
    if (v.exp_stall == 0) begin
      chk($sformatf("v%0d pass stall", i), 32'(stall_mem), 32'd0);
      chk($sformatf("v%0d pass wdata", i), wb_wdata, v.d);
      chk($sformatf("v%0d pass wd/wreg", i), {26'd0, wb_wd, wb_wreg}, {26'd0, v.wd, v.wreg});
      bubble();
      return;
    end
    chk($sformatf("v%0d detect stall/wreg", i), {30'd0, stall_mem, wb_wreg}, 32'd2);
    @(posedge clk); #1;
    bubble();
    stalls = 1; bad_wreg = 0; fin = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!stall_mem) begin fin = 1; break; end
      stalls++;
      if (wb_wreg) bad_wreg++;
    end
    chk($sformatf("v%0d reached FIN", i), 32'(fin), 32'd1);
    chk($sformatf("v%0d stall cycles", i), 32'(stalls), 32'(v.exp_stall));
    chk($sformatf("v%0d wreg during stall", i), 32'(bad_wreg), 32'd0);
    chk($sformatf("v%0d wb_wreg", i), 32'(wb_wreg), 32'(v.exp_wreg));
    chk($sformatf("v%0d wb_wdata", i), wb_wdata, v.exp_data);
    chk($sformatf("v%0d wb_wd", i), 32'(wb_wd), 32'(v.wd));
    ld = (v.rd != 3'd0) && (v.rd < 3'd6);
    nb = ld ? ((v.rd == 3'd3) ? 4 : (v.rd == 3'd2 || v.rd == 3'd5) ? 2 : 1)
            : ((v.wr == 2'd3) ? 4 : (v.wr == 2'd2) ? 2 : 1);
    n = log_q.size();
    chk($sformatf("v%0d byte count", i), 32'(n), 32'(nb));
    for (int j = 0; j < nb && j < n; j++) begin
      chk($sformatf("v%0d b%0d addr", i, j), log_q[j].a, v.a + 32'(j));
      chk($sformatf("v%0d b%0d wr", i, j), 32'(log_q[j].wr), 32'(!ld));
      if (!ld) chk($sformatf("v%0d b%0d dout", i, j), 32'(log_q[j].d), 32'(v.d[8*j +: 8]));
    end
    @(negedge clk);
    chk($sformatf("v%0d wreg after FIN", i), 32'(wb_wreg), 32'd0);
  endtask

  initial begin
    int bad;
    vec_t v;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    mem[8'h20] = 8'h80;
    mem[8'hFF] = 8'h34; mem[8'h00] = 8'h12;
    mem[8'h40] = 8'h81; mem[8'h41] = 8'hF2; mem[8'h42] = 8'h33; mem[8'h43] = 8'h94;

    vq.push_back('{3'd0, 2'd3, 32'h100,      32'hA1B2C3D4, 5'd0,  1'b0, 9, 32'hA1B2C3D4, 1'b0});
    vq.push_back('{3'd1, 2'd0, 32'h20,       32'h0,        5'd5,  1'b1, 3, 32'hFFFFFF80, 1'b1});
    vq.push_back('{3'd4, 2'd0, 32'h20,       32'h0,        5'd6,  1'b1, 3, 32'h00000080, 1'b1});
    vq.push_back('{3'd2, 2'd0, 32'h40,       32'h0,        5'd8,  1'b1, 5, 32'hFFFFF281, 1'b1});
    vq.push_back('{3'd5, 2'd0, 32'h40,       32'h0,        5'd9,  1'b1, 5, 32'h0000F281, 1'b1});
    vq.push_back('{3'd3, 2'd0, 32'h40,       32'h0,        5'd10, 1'b1, 9, 32'h9433F281, 1'b1});
    vq.push_back('{3'd4, 2'd3, 32'h20,       32'hDEADBEEF, 5'd11, 1'b1, 3, 32'h00000080, 1'b1});
    vq.push_back('{3'd6, 2'd0, 32'h0,        32'h12345678, 5'd12, 1'b1, 0, 32'h0,        1'b0});
    vq.push_back('{3'd0, 2'd0, 32'h0,        32'hCAFEF00D, 5'd13, 1'b1, 0, 32'h0,        1'b0});
    vq.push_back('{3'd0, 2'd1, 32'h30,       32'h1122335A, 5'd14, 1'b0, 3, 32'h1122335A, 1'b0});
`ifndef MEM_STAGE_MISALIGN_TRAP_EN
    vq.push_back('{3'd2, 2'd0, 32'hFFFFFFFF, 32'h0,        5'd7,  1'b1, 5, 32'h00001234, 1'b1});
    vq.push_back('{3'd0, 2'd2, 32'h31,       32'h0000BEEF, 5'd15, 1'b0, 5, 32'h0000BEEF, 1'b0});
`endif

    // Reset: outputs quiet even with a live passthrough instruction on the inputs
    rst = 1'b1;
    mem_read = 3'd0; mem_write = 2'd0; mem_wd = 5'd9; mem_wreg = 1'b1;
    mem_waddr = 32'h55; mem_wdata = 32'hFFFF0000;
    #12;
    chk("reset wb", {wb_wdata[26:0], wb_wd}, 32'd0);
    chk("reset wreg/stall/misal", {29'd0, wb_wreg, stall_mem, misalign_err}, 32'd0);
    chk("reset ram bus", {ram.ram_addr[22:0], ram.ram_dout, ram.ram_en}, 32'd0);
    chk("reset ram_wr", 32'(ram.ram_wr), 32'd0);
    @(negedge clk); rst = 1'b0;
    bubble();

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      run_op(v, i);
    end

    // LW with 3-cycle ack: 1 + 4*(1+3) stall cycles, bus held steady through WAIT
    ack_dly = 3;
    v = '{3'd3, 2'd0, 32'h40, 32'h0, 5'd20, 1'b1, 17, 32'h9433F281, 1'b1};
    run_op(v, 100);
    chk("bus stable in WAIT", 32'(instab), 32'd0);

    // Reset asserted in the second WAIT cycle of an LW
    @(negedge clk);
    mem_read = 3'd3; mem_waddr = 32'h40; mem_wd = 5'd3; mem_wreg = 1'b1;
    @(posedge clk); #1; bubble();
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst mid-LW en/stall/wreg", {29'd0, ram.ram_en, stall_mem, wb_wreg}, 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (ram.ram_en || wb_wreg || stall_mem) bad++;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ram.ram_en || wb_wreg || stall_mem) bad++;
    end
    chk("rst mid-LW quiet after", 32'(bad), 32'd0);
    ack_dly = 1;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    @(negedge clk);
    mem_read = 3'd3; mem_waddr = 32'h102; mem_wd = 5'd4; mem_wreg = 1'b1;
    #1;
    chk("misal err", 32'(misalign_err), 32'd1);
    chk("misal stall/wreg", {30'd0, stall_mem, wb_wreg}, 32'd0);
    chk("misal wdata", wb_wdata, 32'h102);
    chk("misal wd", 32'(wb_wd), 32'd4);
    @(posedge clk); #1; bubble();
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (ram.ram_en || misalign_err) bad++;
    end
    chk("misal no bus, single pulse", 32'(bad), 32'd0);
`else
    chk("misalign_err tied low", 32'(misal_seen), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the RISC-V core. It sits between the EX/MEM pipeline register and the MEM/WB register.
- Executes loads and stores over a byte-wide data-RAM bus with a req/ack handshake, one byte per transaction, little-endian.
- Stalls the pipeline for the duration of each access. Non-memory instructions pass through combinationally.

Parameters:
- ADDR_W, 32, byte-address width of the RAM bus.
- ACK_TIMEOUT, 0, maximum WAIT cycles per byte before abandoning the access; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mem_read  in  3  load kind: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 treated as none
- mem_write  in  2  store kind: 0 none, 1 SB, 2 SH, 3 SW
- mem_wd  in  5  destination register
- mem_wreg  in  1  register write enable
- mem_waddr  in  32  effective byte address
- mem_wdata  in  32  ALU result (non-mem), store data (store)
- wb_wd  out  5  to MEM/WB
- wb_wreg  out  1  to MEM/WB
- wb_wdata  out  32  to MEM/WB
- stall_mem  out  1  stall request to the stall controller
- ram_en  out  1  byte transaction request
- ram_wr  out  1  1 = write, 0 = read
- ram_addr  out  ADDR_W  byte address
- ram_dout  out  8  write byte
- ram_din  in  8  read byte, valid when ram_ack is high
- ram_ack  in  1  transaction complete
- misalign_err  out  1  misaligned-access pulse (see Optional Feature)

Behaviour:
- States: IDLE, REQ, WAIT, FIN. 2-bit byte counter idx. Registered copies of op, addr, data, wd, wreg, and a 32-bit assembly register acc.
- Reset (asynchronous): state=IDLE, idx=0, acc=0, all latched fields 0.
  - ram_en=0, ram_wr=0, ram_addr=0, ram_dout=0, misalign_err=0.
  - wb_* outputs and stall_mem are 0 while rst is high.
- Reset mid-access abandons the access at once. No further ram_en is issued and no write-back occurs.
- IDLE, no memory op (read kind 0/6/7 and write 0):
  - wb_wd=mem_wd, wb_wreg=mem_wreg, wb_wdata=mem_wdata (combinational); stall_mem=0.
- IDLE, memory op present:
  - stall_mem=1 combinationally; wb_wreg=0.
  - Latch the inputs; length N = 1, 2 or 4 bytes; idx=0; go to REQ.
  - If both a read and a write kind are nonzero, the read wins and the write is ignored.
- REQ (one cycle):
  - ram_en=1, ram_addr = latched addr + idx, wrapping modulo 2^ADDR_W.
  - ram_wr=1 for a store, 0 for a load.
  - ram_dout = data[8*idx+7 : 8*idx].
  - Go to WAIT.
- WAIT:
  - ram_en is held high and address, data and ram_wr are held stable until ram_ack.
  - On ram_ack, for a load: acc[8*idx+7 : 8*idx] = ram_din.
  - After the ack: if idx == N-1 go to FIN, else idx++ and go to REQ.
  - ram_ack outside WAIT is ignored.
- Timeout: if ACK_TIMEOUT > 0 and ram_ack has not arrived after ACK_TIMEOUT WAIT cycles, go to FIN with write-back suppressed (wb_wreg=0).
- stall_mem=1 in IDLE (detect cycle), REQ and WAIT; 0 in FIN.
- FIN (one cycle):
  - Inputs are ignored.
  - wb_wd = latched wd; wb_wreg = latched wreg.
  - wb_wdata for a load:
    - LB: sign-extend acc[7:0]; LBU: zero-extend acc[7:0].
    - LH: sign-extend acc[15:0]; LHU: zero-extend acc[15:0].
    - LW: acc.
  - wb_wdata for a store: latched data.
  - Go to IDLE.
- Latency with single-cycle ack: stall cycles = 1 + 2N (SB 3, SH 5, SW 9; LB 3, LW 9), followed by one FIN cycle.
- Inputs are sampled only in IDLE. Upstream bubbles during REQ/WAIT/FIN have no effect.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined: in the IDLE detect cycle, LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0, produce the following:
  - misalign_err pulses high for that one cycle.
  - No RAM transaction is issued and stall_mem=0.
  - wb_wreg=0, wb_wd=mem_wd, wb_wdata=mem_waddr.
  - The state stays IDLE.
- Undefined: misaligned accesses proceed byte-wise at any address; misalign_err is tied to 0.

Test Plan:
- Reset mid-LW: assert rst in the second WAIT cycle -> state IDLE immediately, ram_en=0, stall_mem=0, no wb_wreg pulse.
- SW addr=0x100, data=0xA1B2C3D4, ack one cycle after each req -> writes 0xD4@0x100, 0xC3@0x101, 0xB2@0x102, 0xA1@0x103; stall_mem high 9 cycles.
- LB addr=0x20, ram_din=0x80 -> wb_wdata=0xFFFFFF80; LBU at the same address -> 0x00000080; each wb_wreg=1 in FIN only.
- LH at 0xFFFFFFFF with macro undefined -> byte addresses 0xFFFFFFFF then 0x00000000. Bytes 0x34, 0x12 -> wb_wdata=0x00001234.
- LW with ack delayed 3 cycles per byte -> ram_en and ram_addr held stable through WAIT; stall_mem high 1 + 4*(1+3) = 17 cycles; result correct.
- Macro defined, LW addr=0x102 -> misalign_err=1 for one cycle, ram_en never asserted, wb_wreg=0, stall_mem=0.
